// File: rtl/bios_ram_loader.sv
// Boot-image writer: frames a byte stream (MAGIC, LEN, data, SUM) and writes
// the data words into a ROM-layout RAM, verifying header and checksum.
module bios_ram_loader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter logic [31:0] MAGIC      = 32'hDEADBEEF
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic                  start,
  input  logic                  rxValid,
  input  logic [7:0]            rxData,
  output logic                  rxReady,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [31:0]           writeData,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            errorCode,
  output logic [ADDR_WIDTH:0]   wordCount
);

  localparam int unsigned CW      = ADDR_WIDTH + 1;
  localparam logic [31:0] MAX_LEN = 32'(64'd1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_MAGIC, S_LENGTH, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [CW-1:0]         len_q, len_d;
  logic [31:0]           sum_q, sum_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            code_q, code_d;
  logic [CW-1:0]         wc_q, wc_d;

  logic        xfer;
  logic        word_done;
  logic [31:0] word_be;
  logic [31:0] word_rom;

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    len_d   = len_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    code_d  = code_q;
    wc_d    = wc_q;

    // busy_q doubles as rxReady: bytes are only taken in the framing states
    xfer      = rxValid && busy_q;
    word_done = xfer && (cnt_q == 2'd3);
    word_be   = {shift_q, rxData};
    word_rom  = {rxData, shift_q[7:0], shift_q[15:8], shift_q[23:16]};

    if (xfer) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word_be[23:0];
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = 2'd0;
          wc_d    = '0;
          sum_d   = '0;
          cnt_d   = 2'd0;
          state_d = S_MAGIC;
        end
      end
      S_MAGIC: begin
        if (word_done) begin
          if (word_be == MAGIC) begin
            state_d = S_LENGTH;
          end else begin
            error_d = 1'b1;
            code_d  = 2'd1;
            state_d = S_ERROR;
          end
        end
      end
      S_LENGTH: begin
        if (word_done) begin
          if ((word_be == 32'd0) || (word_be > MAX_LEN)) begin
            error_d = 1'b1;
            code_d  = 2'd2;
            state_d = S_ERROR;
          end else begin
            len_d   = CW'(word_be);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_done) begin
          we_d   = 1'b1;
          addr_d = wc_q[ADDR_WIDTH-1:0];
          data_d = word_rom;
          sum_d  = sum_q + word_rom;
          wc_d   = wc_q + CW'(1);
          if (wc_d == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (word_done) begin
          if (word_rom == sum_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            error_d = 1'b1;
            code_d  = 2'd3;
            state_d = S_ERROR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MAGIC) || (state_d == S_LENGTH) ||
             (state_d == S_DATA)  || (state_d == S_CHECK);
  end

  assign rxReady      = busy_q;
  assign busy         = busy_q;
  assign writeEnable  = we_q;
  assign writeAddress = addr_q;
  assign writeData    = data_q;
  assign done         = done_q;
  assign error        = error_q;
  assign errorCode    = code_q;
  assign wordCount    = wc_q;

endmodule

// File: tb/tb_bios_ram_loader.sv
// Directed + randomized bench for bios_ram_loader; expectations come from a
// stream-level model that parses the byte list into writes and final status.
module tb_bios_ram_loader;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        start = 1'b0;
  logic        rxValid = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxReady;
  logic        writeEnable;
  logic [10:0] writeAddress;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  errorCode;
  logic [11:0] wordCount;

  always #5 clock = ~clock;

  bios_ram_loader dut (
    .clock(clock), .nReset(nReset), .start(start), .rxValid(rxValid),
    .rxData(rxData), .rxReady(rxReady), .writeEnable(writeEnable),
    .writeAddress(writeAddress), .writeData(writeData), .busy(busy),
    .done(done), .error(error), .errorCode(errorCode), .wordCount(wordCount)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  stream[$];
  logic [42:0] got_w[$];
  logic [42:0] exp_w[$];
  logic        exp_done, exp_err;
  logic [1:0]  exp_code;
  logic [11:0] exp_wc;
  logic        we_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Write monitor: record every strobe and insist it never lasts two cycles
  always @(negedge clock) begin
    if (writeEnable) begin
      got_w.push_back({writeAddress, writeData});
      check("we_one_cycle", 64'(we_prev), 64'd0);
    end
    we_prev <= writeEnable;
  end

  function automatic logic [31:0] be_at(input int i);
    return {stream[i], stream[i+1], stream[i+2], stream[i+3]};
  endfunction

  function automatic logic [31:0] le_at(input int i);
    return {stream[i+3], stream[i+2], stream[i+1], stream[i]};
  endfunction

  // Reference: interpret the whole stream by the framing rules
  task automatic model();
    logic [31:0] len, sum, w;
    exp_w.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'd0; exp_wc = 12'd0;
    if (be_at(0) != 32'hDEADBEEF) begin
      exp_err = 1'b1; exp_code = 2'd1; return;
    end
    len = be_at(4);
    if (len == 0 || len > 2048) begin
      exp_err = 1'b1; exp_code = 2'd2; return;
    end
    sum = 32'd0;
    for (int i = 0; i < int'(len); i++) begin
      w = le_at(8 + 4 * i);
      exp_w.push_back({11'(i), w});
      sum += w;
    end
    exp_wc = 12'(len);
    if (le_at(8 + 4 * int'(len)) == sum) exp_done = 1'b1;
    else begin
      exp_err = 1'b1; exp_code = 2'd3;
    end
  endtask

  task automatic push_be(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) stream.push_back(w[8*k +: 8]);
  endtask

  task automatic push_le(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
  endtask

  // Appends the correct SUM for the data words already in the stream
  task automatic push_sum(input int len);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < len; i++) s += le_at(8 + 4 * i);
    push_le(s);
  endtask

  task automatic build_scen1();
    stream.delete();
    push_be(32'hDEADBEEF);
    push_be(32'h00000002);
    push_be(32'hDEADBEEF);
    push_be(32'h15000000);
    push_sum(2);
  endtask

  task automatic build_random(input int len);
    stream.delete();
    push_be(32'hDEADBEEF);
    push_be(32'(len));
    for (int i = 0; i < len; i++) push_le($urandom);
    push_sum(len);
  endtask

  task automatic send(input int n, input int max_gap, input int poke);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clock);
        rxValid = 1'b0;
        start = 1'b0;
      end
      @(negedge clock);
      rxValid = 1'b1;
      rxData = stream[i];
      start = (i == poke);
    end
    @(negedge clock);
    rxValid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic run(input string tag, input int max_gap, input int poke);
    model();
    got_w.delete();
    pulse_start();
    send(stream.size(), max_gap, poke);
    for (int k = 0; k < 50 && busy; k++) @(negedge clock);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_nwr"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check({tag, "_wr"}, 64'(got_w[i]), 64'(exp_w[i]));
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    check({tag, "_code"}, 64'(errorCode), 64'(exp_code));
    check({tag, "_wc"}, 64'(wordCount), 64'(exp_wc));
    check({tag, "_rxready"}, 64'(rxReady), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_outputs", 64'({rxReady, writeEnable, writeAddress, writeData, busy,
                                done, error, errorCode, wordCount}), 64'd0);
    nReset = 1'b1;

    build_scen1();
    check("s1_exp_w0", 64'(le_at(8)), 64'hEFBEADDE);
    check("s1_exp_w1", 64'(le_at(12)), 64'h00000015);
    run("s1", 0, -1);

    stream[3] = 8'hEE;
    run("bad_magic", 0, -1);

    stream.delete();
    push_be(32'hDEADBEEF); push_be(32'h0); push_be(32'h12345678);
    run("len0", 0, -1);
    stream.delete();
    push_be(32'hDEADBEEF); push_be(32'h00000801); push_be(32'h12345678);
    run("len2049", 0, -1);
    build_random(2048);
    run("len2048", 0, -1);
    check("len2048_last_addr", 64'(got_w[$][42:32]), 64'h7FF);

    build_scen1();
    stream[stream.size() - 1] = 8'hDF;
    run("bad_sum", 0, -1);

    build_scen1();
    run("gapped", 5, 6);

    for (int r = 0; r < 4; r++) begin
      build_random($urandom_range(1, 24));
      if (r == 2) stream[stream.size() - 2] ^= 8'h10;
      run("random", 3, -1);
    end

    build_scen1();
    pulse_start();
    send(10, 0, -1);
    @(negedge clock);
    nReset = 1'b0;
    @(negedge clock);
    check("midload_reset", 64'({rxReady, writeEnable, writeAddress, writeData, busy,
                                done, error, errorCode, wordCount}), 64'd0);
    nReset = 1'b1;
    run("after_reset", 1, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
